// File: rtl/rll_key_pkg.sv
// Shared types and sizing for the RLL key loader.
// Optional feature macro: RLL_KEY_PARITY_EN (adds an even-parity beat after the key bits).
package rll_key_pkg;

  localparam int KEY_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    COMMIT
  } key_ld_state_t;

  // The bit counter must be able to hold KEY_WIDTH itself so it never wraps.
  function automatic int cnt_width(input int key_width);
    return $clog2(key_width + 1);
  endfunction

  localparam int CNT_W = cnt_width(KEY_WIDTH_DEF);

endpackage

// File: rtl/rll_key_shreg.sv
// Indexed shadow register: one bit written per beat at wr_idx, whole register cleared by clr.
// clr wins over wr_en so an abort can never leave a stray bit behind.
module rll_key_shreg
  import rll_key_pkg::*;
#(
  parameter int WIDTH = KEY_WIDTH_DEF,
  parameter int IDX_W = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_bit,
  output logic [WIDTH-1:0] shadow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (clr) begin
      shadow <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          shadow[i] <= wr_bit;
        end
      end
    end
  end

endmodule

// File: rtl/rll_key_loader.sv
// Serial key loader for the RLL32 locked netlists: shifts the key in LSB first, commits it atomically.
// Optional feature macro: RLL_KEY_PARITY_EN (even-parity beat checked before commit, sticky load_err).
module rll_key_loader
  import rll_key_pkg::*;
#(
  parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
  parameter logic [KEY_WIDTH-1:0] RST_KEY   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 key_sdi,
  input  logic                 key_sdi_valid,
  input  logic                 zeroize,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_armed,
  output logic                 busy,
  output logic                 load_err
);

  localparam int            CW       = cnt_width(KEY_WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(KEY_WIDTH - 1);

  key_ld_state_t          state;
  logic [CW-1:0]          cnt;
  logic [KEY_WIDTH-1:0]   shadow;
  logic                   shadow_clr;
  logic                   shadow_wr;

  // Both zeroize and a (re)start wipe the shadow; writes only land while shifting.
  assign shadow_clr = zeroize | load_start;
  assign shadow_wr  = (state == SHIFT) & key_sdi_valid;
  assign busy       = (state != IDLE);

  rll_key_shreg #(
    .WIDTH (KEY_WIDTH),
    .IDX_W (CW)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .clr    (shadow_clr),
    .wr_en  (shadow_wr),
    .wr_idx (cnt),
    .wr_bit (key_sdi),
    .shadow (shadow)
  );

  // key_out only ever changes on commit, zeroize or reset, so the netlist never sees a partial key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      key_out   <= RST_KEY;
      key_armed <= 1'b0;
      load_err  <= 1'b0;
    end else if (zeroize) begin
      state     <= IDLE;
      cnt       <= '0;
      key_out   <= RST_KEY;
      key_armed <= 1'b0;
    end else if (load_start) begin
      state    <= SHIFT;
      cnt      <= '0;
      load_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        SHIFT: begin
          if (key_sdi_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
`ifdef RLL_KEY_PARITY_EN
              state <= PARITY;
`else
              state <= COMMIT;
`endif
            end
          end
        end
`ifdef RLL_KEY_PARITY_EN
        PARITY: begin
          if (key_sdi_valid) begin
            if (key_sdi == ^shadow) begin
              state <= COMMIT;
            end else begin
              load_err <= 1'b1;
              state    <= IDLE;
            end
          end
        end
`endif
        COMMIT: begin
          key_out   <= shadow;
          key_armed <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed self-checking bench for rll_key_loader; inputs driven and outputs sampled on the falling edge.
// Parity checks are compiled in when RLL_KEY_PARITY_EN is defined.
module tb_rll_key_loader;

`ifdef RLL_KEY_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        key_sdi;
  logic        key_sdi_valid;
  logic        zeroize;
  logic [31:0] key_out;
  logic        key_armed;
  logic        busy;
  logic        load_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_cycles;

  rll_key_loader #(
    .KEY_WIDTH (32),
    .RST_KEY   (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .key_sdi       (key_sdi),
    .key_sdi_valid (key_sdi_valid),
    .zeroize       (zeroize),
    .key_out       (key_out),
    .key_armed     (key_armed),
    .busy          (busy),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulses load_start (with a decoy valid bit that must be ignored), then shifts nbits of key.
  // gap inserts a valid=0 beat carrying the inverted bit between accepted bits.
  task automatic applyStimulus(input logic [31:0] key, input int nbits, input bit gap,
                               input bit par, output int bcnt);
    bcnt          = 0;
    load_start    = 1'b1;
    key_sdi       = 1'b1;
    key_sdi_valid = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (busy) bcnt++;
      key_sdi       = key[i];
      key_sdi_valid = 1'b1;
      @(negedge clk);
      if (gap && i < nbits - 1) begin
        if (busy) bcnt++;
        key_sdi       = ~key[i];
        key_sdi_valid = 1'b0;
        @(negedge clk);
      end
    end
    if (PAR_EN && nbits == 32) begin
      if (busy) bcnt++;
      key_sdi       = par;
      key_sdi_valid = 1'b1;
      @(negedge clk);
    end
    key_sdi       = 1'b0;
    key_sdi_valid = 1'b0;
  endtask

  // Called in the COMMIT cycle: old key must still be visible, new key one clock later.
  task automatic finishLoad(input string tag, input logic [31:0] prev_key, input logic prev_armed,
                            input logic [31:0] new_key);
    checkOutput({tag, "_pre_key"}, key_out, prev_key);
    checkOutput({tag, "_pre_armed"}, {31'b0, key_armed}, {31'b0, prev_armed});
    @(negedge clk);
    checkOutput({tag, "_key"}, key_out, new_key);
    checkOutput({tag, "_armed"}, {31'b0, key_armed}, 32'd1);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] k;

    rst           = 1'b1;
    load_start    = 1'b0;
    key_sdi       = 1'b0;
    key_sdi_valid = 1'b0;
    zeroize       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_key", key_out, 32'h0);
    checkOutput("rst_armed", {31'b0, key_armed}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_err", {31'b0, load_err}, 32'd0);

    // Back-to-back valid beats.
    k = 32'hA5A5_0F0F;
    applyStimulus(k, 32, 1'b0, ^k, busy_cycles);
    if (busy) busy_cycles++;
    finishLoad("full", 32'h0, 1'b0, k);
    checkOutput("full_busy_cycles", busy_cycles, 33 + PAR_EN);

    // Toggling valid after a zeroize so the commit is observable.
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    checkOutput("zero_key", key_out, 32'h0);
    checkOutput("zero_armed", {31'b0, key_armed}, 32'd0);
    applyStimulus(k, 32, 1'b1, ^k, busy_cycles);
    finishLoad("gap", 32'h0, 1'b0, k);

    // Aborted reload must not disturb the committed key.
    k = 32'hFFFF_FFFF;
    applyStimulus(k, 32, 1'b0, ^k, busy_cycles);
    finishLoad("ones", 32'hA5A5_0F0F, 1'b1, k);
    applyStimulus(32'h0000_0001, 10, 1'b0, 1'b1, busy_cycles);
    checkOutput("abort_key", key_out, 32'hFFFF_FFFF);
    checkOutput("abort_busy", {31'b0, busy}, 32'd1);
    applyStimulus(32'h0000_0001, 32, 1'b0, 1'b1, busy_cycles);
    finishLoad("reload", 32'hFFFF_FFFF, 1'b1, 32'h0000_0001);

    // zeroize outranks a simultaneous load_start mid-shift.
    applyStimulus(32'hDEAD_BEEF, 20, 1'b0, 1'b0, busy_cycles);
    zeroize       = 1'b1;
    load_start    = 1'b1;
    key_sdi_valid = 1'b1;
    @(negedge clk);
    zeroize       = 1'b0;
    load_start    = 1'b0;
    key_sdi_valid = 1'b0;
    checkOutput("zload_key", key_out, 32'h0);
    checkOutput("zload_armed", {31'b0, key_armed}, 32'd0);
    checkOutput("zload_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("zload_busy2", {31'b0, busy}, 32'd0);

    // Asynchronous reset in the middle of a shift.
    k = 32'hCAFE_F00D;
    applyStimulus(k, 32, 1'b0, ^k, busy_cycles);
    finishLoad("cafe", 32'h0, 1'b0, k);
    applyStimulus(32'h0, 15, 1'b0, 1'b0, busy_cycles);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_key", key_out, 32'h0);
    checkOutput("arst_armed", {31'b0, key_armed}, 32'd0);
    checkOutput("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    k = 32'h1234_5678;
    applyStimulus(k, 32, 1'b0, ^k, busy_cycles);
    finishLoad("post_rst", 32'h0, 1'b0, k);

`ifdef RLL_KEY_PARITY_EN
    // 0x3 has even parity bit 0; sending 1 must be rejected.
    applyStimulus(32'h0000_0003, 32, 1'b0, 1'b1, busy_cycles);
    checkOutput("par_bad_err", {31'b0, load_err}, 32'd1);
    checkOutput("par_bad_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("par_bad_key", key_out, 32'h1234_5678);
    checkOutput("par_bad_armed", {31'b0, key_armed}, 32'd1);
    applyStimulus(32'h0000_0003, 32, 1'b0, 1'b0, busy_cycles);
    checkOutput("par_ok_err", {31'b0, load_err}, 32'd0);
    finishLoad("par_ok", 32'h1234_5678, 1'b1, 32'h0000_0003);
`else
    checkOutput("err_tied", {31'b0, load_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
